// File: rtl/ge_avl_pkg.sv
// Shared definitions for the effect Avalon responder: register map, STATUS layout, response FSM.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package ge_avl_pkg;

  // Register map (word addresses on avs_address)
  localparam logic [4:0] ADDR_GAIN   = 5'h01;
  localparam logic [4:0] ADDR_BOOST  = 5'h02;
  localparam logic [4:0] ADDR_STATUS = 5'h03;
  localparam logic [4:0] ADDR_OUTPUT = 5'h05;
  localparam logic [4:0] ADDR_INPUT  = 5'h06;

  // STATUS bit positions
  localparam int ST_CAP_EMPTY   = 0;
  localparam int ST_CAP_FULL    = 1;
  localparam int ST_PLAY_EMPTY  = 2;
  localparam int ST_PLAY_FULL   = 3;
  localparam int ST_CAP_OVF     = 4;
  localparam int ST_PLAY_OVF    = 5;
  localparam int ST_CAP_UNF     = 6;
  localparam int ST_BYPASS      = 7;
  localparam int ST_CAP_LVL_LO  = 8;
  localparam int ST_PLAY_LVL_LO = 16;

  // Read-response state: RESP is the cycle in which readdatavalid is shown
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } resp_state_e;

  // FIFO levels are up to 9 bits wide (DEPTH=256 gives 256); the STATUS field is 8 bits,
  // so a completely full 256-entry FIFO reports 255 instead of wrapping to 0.
  function automatic logic [7:0] sat_level(input logic [8:0] lvl);
    return (lvl > 9'd255) ? 8'hFF : lvl[7:0];
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Sample FIFO with wrap-around pointers; level spans 0..DEPTH inclusive.
// Latency: push visible at head/level the cycle after; head is combinational from storage.
// Backpressure: none; a push to a full FIFO is dropped unless a pop happens in the same cycle.
module sample_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk500,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A pop only happens when there is data; a push into a full FIFO is allowed only
  // when the head leaves in the same cycle (full implies non-empty, so the pop is real).
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Extra MSB on the pointers distinguishes full from empty
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO and masks any concurrent push/pop
  always_ff @(posedge clk500) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sample storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk500) begin
    if (!reset && do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/effect_avl_responder.sv
// Avalon-MM register responder for the distortion effect: gain/boost/bypass regs plus capture/playback sample FIFOs.
// Latency: avs_readdata/avs_readdatavalid exactly 1 cycle after avs_read; reads accepted every cycle.
// Backpressure: none on Avalon or capture (overflow/underflow are flagged sticky); playback honours play_ready.
module effect_avl_responder
  import ge_avl_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk500,
  input  logic              reset,
  input  logic [4:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic [DATA_W-1:0] gain_o,
  output logic [DATA_W-1:0] boost_o,
  output logic              bypass_o,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              cap_valid,
  output logic [DATA_W-1:0] play_data,
  output logic              play_valid,
  input  logic              play_ready
);

  localparam int AW = $clog2(DEPTH);

  resp_state_e       state_q;
  resp_state_e       state_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rd_mux;
  logic [31:0]       status_word;

  logic              wr_acc;
  logic              cap_pop;
  logic              play_push;
  logic              play_pop;
  logic              cap_ovf_set;
  logic              play_ovf_set;
  logic              cap_unf_set;
  logic              status_wr;
  logic              cap_ovf_q;
  logic              play_ovf_q;
  logic              cap_unf_q;

  logic [DATA_W-1:0] cap_head;
  logic              cap_full;
  logic              cap_empty;
  logic [AW:0]       cap_level;
  logic              play_full;
  logic              play_empty;
  logic [AW:0]       play_level;

  // A simultaneous read and write services the read and drops the write
  assign wr_acc    = avs_write && !avs_read;
  assign status_wr = wr_acc && (avs_address == ADDR_STATUS);
  assign cap_pop   = avs_read && (avs_address == ADDR_INPUT);
  assign play_push = wr_acc && (avs_address == ADDR_OUTPUT);
  assign play_pop  = play_valid && play_ready;

  // Overflow only when full and the head is not leaving this cycle
  assign cap_ovf_set  = cap_valid && cap_full && !cap_pop;
  assign play_ovf_set = play_push && play_full && !play_pop;
  assign cap_unf_set  = cap_pop && cap_empty;

  sample_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_cap_fifo (
    .clk500    (clk500),
    .reset     (reset),
    .push      (cap_valid),
    .push_data (cap_data),
    .pop       (cap_pop),
    .head      (cap_head),
    .full      (cap_full),
    .empty     (cap_empty),
    .level     (cap_level)
  );

  sample_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_play_fifo (
    .clk500    (clk500),
    .reset     (reset),
    .push      (play_push),
    .push_data (avs_writedata),
    .pop       (play_pop),
    .head      (play_data),
    .full      (play_full),
    .empty     (play_empty),
    .level     (play_level)
  );

  assign play_valid = !play_empty;

  // Control registers: gain, boost and the bypass bit living in STATUS
  always_ff @(posedge clk500) begin
    if (reset) begin
      gain_o   <= '0;
      boost_o  <= '0;
      bypass_o <= 1'b0;
    end else if (wr_acc) begin
      if (avs_address == ADDR_GAIN)  gain_o   <= avs_writedata;
      if (avs_address == ADDR_BOOST) boost_o  <= avs_writedata;
      if (status_wr)                 bypass_o <= avs_writedata[ST_BYPASS];
    end
  end

  // Sticky error flags: write-1-to-clear, but a same-cycle set wins over the clear
  always_ff @(posedge clk500) begin
    if (reset) begin
      cap_ovf_q  <= 1'b0;
      play_ovf_q <= 1'b0;
      cap_unf_q  <= 1'b0;
    end else begin
      cap_ovf_q  <= (cap_ovf_q  && !(status_wr && avs_writedata[ST_CAP_OVF]))  || cap_ovf_set;
      play_ovf_q <= (play_ovf_q && !(status_wr && avs_writedata[ST_PLAY_OVF])) || play_ovf_set;
      cap_unf_q  <= (cap_unf_q  && !(status_wr && avs_writedata[ST_CAP_UNF]))  || cap_unf_set;
    end
  end

  // Assemble the STATUS word from live FIFO flags, sticky bits and levels
  always_comb begin
    status_word = '0;
    status_word[ST_CAP_EMPTY]            = cap_empty;
    status_word[ST_CAP_FULL]             = cap_full;
    status_word[ST_PLAY_EMPTY]           = play_empty;
    status_word[ST_PLAY_FULL]            = play_full;
    status_word[ST_CAP_OVF]              = cap_ovf_q;
    status_word[ST_PLAY_OVF]             = play_ovf_q;
    status_word[ST_CAP_UNF]              = cap_unf_q;
    status_word[ST_BYPASS]               = bypass_o;
    status_word[ST_CAP_LVL_LO  +: 8]     = sat_level(9'(cap_level));
    status_word[ST_PLAY_LVL_LO +: 8]     = sat_level(9'(play_level));
  end

  // Read data select; unmapped and write-only addresses read as zero
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_GAIN:   rd_mux = gain_o;
      ADDR_BOOST:  rd_mux = boost_o;
      ADDR_STATUS: rd_mux = DATA_W'(status_word);
      ADDR_INPUT:  rd_mux = cap_empty ? '0 : cap_head;
      default:     rd_mux = '0;
    endcase
  end

  // Read data is captured on the read cycle and presented the next
  always_ff @(posedge clk500) begin
    if (reset)         rdata_q <= '0;
    else if (avs_read) rdata_q <= rd_mux;
  end

  assign avs_readdata = rdata_q;

  // Response FSM state register
  always_ff @(posedge clk500) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Response FSM next state: every accepted read produces one RESP cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = avs_read ? S_RESP : S_IDLE;
      S_RESP:  state_d = avs_read ? S_RESP : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Response FSM output: a reset arriving mid-transaction suppresses the pending valid
  always_comb begin
    avs_readdatavalid = (state_q == S_RESP) && !reset;
  end

endmodule

// File: tb/tb_effect_avl_responder.sv
module tb_effect_avl_responder;

  logic        clk500 = 1'b0;
  logic        reset;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [31:0] gain_o;
  logic [31:0] boost_o;
  logic        bypass_o;
  logic [31:0] cap_data;
  logic        cap_valid;
  logic [31:0] play_data;
  logic        play_valid;
  logic        play_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk500 = ~clk500;

  effect_avl_responder #(.DEPTH(16), .DATA_W(32)) dut (
    .clk500            (clk500),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .gain_o            (gain_o),
    .boost_o           (boost_o),
    .bypass_o          (bypass_o),
    .cap_data          (cap_data),
    .cap_valid         (cap_valid),
    .play_data         (play_data),
    .play_valid        (play_valid),
    .play_ready        (play_ready)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        exp_vld;
    logic [31:0] exp_rdata;
    logic [31:0] exp_gain;
    logic [31:0] exp_boost;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vt [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge
  task automatic cyc();
    @(posedge clk500);
    #1;
  endtask

  task automatic rd_status(input string name, input logic [31:0] exp);
    avs_read    = 1'b1;
    avs_write   = 1'b0;
    avs_address = 5'h03;
    cyc();
    avs_read = 1'b0;
    chk({name, "_vld"}, {31'd0, avs_readdatavalid}, 32'd1);
    chk(name, avs_readdata, exp);
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b1, 5'h01, 32'h0000_0040, 1'b0, 32'h0,         32'h40, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 5'h01, 32'h0,         1'b1, 32'h40,        32'h40, 32'h0};
    vt[2]  = '{1'b0, 1'b0, 5'h01, 32'h0,         1'b0, 32'h0,         32'h40, 32'h0};
    vt[3]  = '{1'b0, 1'b1, 5'h02, 32'h0000_1234, 1'b0, 32'h0,         32'h40, 32'h1234};
    vt[4]  = '{1'b1, 1'b0, 5'h02, 32'h0,         1'b1, 32'h1234,      32'h40, 32'h1234};
    vt[5]  = '{1'b1, 1'b0, 5'h01, 32'h0,         1'b1, 32'h40,        32'h40, 32'h1234};
    vt[6]  = '{1'b1, 1'b1, 5'h01, 32'h0000_0099, 1'b1, 32'h40,        32'h40, 32'h1234};
    vt[7]  = '{1'b1, 1'b0, 5'h01, 32'h0,         1'b1, 32'h40,        32'h40, 32'h1234};
    vt[8]  = '{1'b0, 1'b1, 5'h06, 32'h0000_FFFF, 1'b0, 32'h0,         32'h40, 32'h1234};
    vt[9]  = '{1'b1, 1'b0, 5'h05, 32'h0,         1'b1, 32'h0,         32'h40, 32'h1234};
    vt[10] = '{1'b1, 1'b0, 5'h1F, 32'h0,         1'b1, 32'h0,         32'h40, 32'h1234};
    vt[11] = '{1'b0, 1'b1, 5'h00, 32'h0000_DEAD, 1'b0, 32'h0,         32'h40, 32'h1234};
    vt[12] = '{1'b1, 1'b0, 5'h03, 32'h0,         1'b1, 32'h0000_0005, 32'h40, 32'h1234};
    vt[13] = '{1'b0, 1'b1, 5'h04, 32'h0000_00FF, 1'b0, 32'h0,         32'h40, 32'h1234};
    vt[14] = '{1'b1, 1'b0, 5'h04, 32'h0,         1'b1, 32'h0,         32'h40, 32'h1234};

    reset = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    cap_data = '0; cap_valid = 1'b0; play_ready = 1'b0;
    cyc(); cyc();
    chk("rst_vld",    {31'd0, avs_readdatavalid}, 32'd0);
    chk("rst_rdata",  avs_readdata, 32'd0);
    chk("rst_gain",   gain_o, 32'd0);
    chk("rst_boost",  boost_o, 32'd0);
    chk("rst_bypass", {31'd0, bypass_o}, 32'd0);
    chk("rst_pvalid", {31'd0, play_valid}, 32'd0);
    reset = 1'b0;

    // Register access table
    for (int i = 0; i < NVEC; i++) begin
      avs_read = vt[i].rd; avs_write = vt[i].wr;
      avs_address = vt[i].addr; avs_writedata = vt[i].wdata;
      cyc();
      chk($sformatf("vec%0d_vld", i), {31'd0, avs_readdatavalid}, {31'd0, vt[i].exp_vld});
      if (vt[i].exp_vld) chk($sformatf("vec%0d_rdata", i), avs_readdata, vt[i].exp_rdata);
      chk($sformatf("vec%0d_gain", i), gain_o, vt[i].exp_gain);
      chk($sformatf("vec%0d_boost", i), boost_o, vt[i].exp_boost);
    end
    avs_read = 1'b0; avs_write = 1'b0;

    // Capture overflow: 17 samples into a 16-deep FIFO
    for (int i = 1; i <= 17; i++) begin
      cap_valid = 1'b1; cap_data = i; cyc();
    end
    cap_valid = 1'b0;
    rd_status("cap_full_status", 32'h0000_1016);
    for (int i = 1; i <= 16; i++) begin
      avs_read = 1'b1; avs_address = 5'h06; cyc();
      chk($sformatf("cap_pop%0d", i), avs_readdata, i);
    end
    avs_read = 1'b1; avs_address = 5'h06; cyc();
    avs_read = 1'b0;
    chk("cap_pop_empty", avs_readdata, 32'h0);
    rd_status("cap_unf_status", 32'h0000_0055);

    // Playback single sample with DAC stalled, then released for one cycle
    avs_write = 1'b1; avs_address = 5'h05; avs_writedata = 32'hA5; cyc();
    avs_write = 1'b0;
    chk("play_valid_a5", {31'd0, play_valid}, 32'd1);
    chk("play_data_a5", play_data, 32'hA5);
    play_ready = 1'b1; cyc();
    play_ready = 1'b0;
    chk("play_valid_drained", {31'd0, play_valid}, 32'd0);
    rd_status("play_empty_status", 32'h0000_0055);

    // Playback overflow
    for (int j = 1; j <= 17; j++) begin
      avs_write = 1'b1; avs_address = 5'h05; avs_writedata = 32'h100 + j; cyc();
    end
    avs_write = 1'b0;
    rd_status("play_ovf_status", 32'h0010_0079);
    chk("play_head_first", play_data, 32'h101);

    // Clear all sticky bits and set bypass
    avs_write = 1'b1; avs_address = 5'h03; avs_writedata = 32'hF0; cyc();
    avs_write = 1'b0;
    chk("bypass_set", {31'd0, bypass_o}, 32'd1);
    rd_status("w1c_status", 32'h0010_0089);

    // Push and pop together on a full playback FIFO: level held, no overflow
    avs_write = 1'b1; avs_address = 5'h05; avs_writedata = 32'h77; play_ready = 1'b1; cyc();
    avs_write = 1'b0; play_ready = 1'b0;
    rd_status("full_pushpop_status", 32'h0010_0089);
    chk("play_head_after_pushpop", play_data, 32'h102);

    // Overflow set in the same cycle as its write-1-to-clear: set wins
    for (int k = 0; k < 16; k++) begin
      cap_valid = 1'b1; cap_data = 32'h200 + k; cyc();
    end
    avs_write = 1'b1; avs_address = 5'h03; avs_writedata = 32'h90; cyc();
    cap_valid = 1'b0; avs_write = 1'b0;
    rd_status("set_beats_clr_status", 32'h0010_109A);

    // Drain playback in order
    play_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d_valid", k), {31'd0, play_valid}, 32'd1);
      chk($sformatf("drain%0d_data", k), play_data, (k < 15) ? (32'h102 + k) : 32'h77);
      cyc();
    end
    play_ready = 1'b0;
    chk("drain_done_valid", {31'd0, play_valid}, 32'd0);

    // Reset in the cycle after a read aborts the response
    avs_read = 1'b1; avs_address = 5'h01; cyc();
    chk("pre_rst_vld", {31'd0, avs_readdatavalid}, 32'd1);
    chk("pre_rst_rdata", avs_readdata, 32'h40);
    avs_read = 1'b0; reset = 1'b1; #1;
    chk("rst_mid_vld", {31'd0, avs_readdatavalid}, 32'd0);
    cyc();
    chk("rst2_vld", {31'd0, avs_readdatavalid}, 32'd0);
    chk("rst2_gain", gain_o, 32'd0);
    chk("rst2_bypass", {31'd0, bypass_o}, 32'd0);
    chk("rst2_rdata", avs_readdata, 32'd0);
    reset = 1'b0;
    rd_status("post_rst_status", 32'h0000_0005);

    // Read issued during the reset cycle is ignored
    avs_read = 1'b1; avs_address = 5'h03; reset = 1'b1; cyc();
    avs_read = 1'b0; reset = 1'b0; cyc();
    chk("rd_in_rst_vld", {31'd0, avs_readdatavalid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
